// File: rtl/dmem_uncached_resp.sv
// Local word RAM behind the uncached data-memory port: fixed-latency responses, byte-lane writes, range/conflict errors.
// One request in flight; accept is high only while idle, and the single-cycle ack has no back-pressure.
module dmem_uncached_resp #(
    parameter logic [31:0] BASE_ADDR   = 32'h9000_0000,
    parameter int          DEPTH_WORDS = 256,
    parameter int          WAIT_CYCLES = 1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_data_wr_i,
    input  logic        mem_rd_i,
    input  logic [3:0]  mem_wr_i,
    input  logic        mem_cacheable_i,
    input  logic [10:0] mem_req_tag_i,
    input  logic        mem_invalidate_i,
    input  logic        mem_writeback_i,
    input  logic        mem_flush_i,
    output logic [31:0] mem_data_rd_o,
    output logic        mem_accept_o,
    output logic        mem_ack_o,
    output logic        mem_error_o,
    output logic [10:0] mem_resp_tag_o,
    output logic        busy_o
);

    localparam int          IDX_W    = $clog2(DEPTH_WORDS);
    localparam logic [31:0] SPAN     = 32'(DEPTH_WORDS * 4);
    localparam logic [3:0]  CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              req, xfer, is_wr, in_range, err_now, ram_we;
    logic [31:0]       off, rdata_now;
    logic [IDX_W-1:0]  idx;
    logic              pend_err_q, err_q;
    logic [31:0]       pend_data_q, data_q;
    logic [10:0]       pend_tag_q, tag_q;
    logic [31:0]       ram_q [DEPTH_WORDS];
    logic              unused_bits;

    // Offset arithmetic avoids overflow of BASE_ADDR + span near the top of the address map.
    assign off      = mem_addr_i - BASE_ADDR;
    assign idx      = off[IDX_W+1:2];
    assign in_range = (mem_addr_i >= BASE_ADDR) && (off < SPAN);

    assign is_wr   = |mem_wr_i;
    assign req     = mem_rd_i | is_wr | mem_flush_i | mem_invalidate_i | mem_writeback_i;
    assign err_now = ((mem_rd_i || is_wr) && !in_range) || (mem_rd_i && is_wr);
    assign xfer    = req && mem_accept_o;
    assign ram_we  = xfer && is_wr && !err_now;

    assign rdata_now   = (mem_rd_i && !err_now) ? ram_q[idx] : 32'd0;
    assign unused_bits = ^{off[1:0], off[31:IDX_W+2], mem_cacheable_i};

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        mem_accept_o = 1'b0;
        busy_o       = 1'b1;
        mem_ack_o    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                mem_accept_o = 1'b1;
                busy_o       = 1'b0;
                if (req) begin
                    if (WAIT_CYCLES > 0) begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_INIT;
                    end else begin
                        state_d = ST_RESP;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) state_d = ST_RESP;
                else               cnt_d   = cnt_q - 4'd1;
            end
            ST_RESP: begin
                mem_ack_o = 1'b1;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            pend_err_q  <= 1'b0;
            pend_data_q <= 32'd0;
            pend_tag_q  <= 11'd0;
            err_q       <= 1'b0;
            data_q      <= 32'd0;
            tag_q       <= 11'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (xfer) begin
                pend_err_q  <= err_now;
                pend_data_q <= rdata_now;
                pend_tag_q  <= mem_req_tag_i;
            end
            // Response fields change only on entry to RESP so they hold across the wait period.
            if (state_d == ST_RESP) begin
                err_q  <= (state_q == ST_IDLE) ? err_now       : pend_err_q;
                data_q <= (state_q == ST_IDLE) ? rdata_now     : pend_data_q;
                tag_q  <= (state_q == ST_IDLE) ? mem_req_tag_i : pend_tag_q;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (ram_we) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_wr_i[b]) ram_q[idx][8*b +: 8] <= mem_data_wr_i[8*b +: 8];
            end
        end
    end

    assign mem_data_rd_o  = data_q;
    assign mem_resp_tag_o = tag_q;
    assign mem_error_o    = mem_ack_o & err_q;

endmodule

// File: tb/tb_dmem_uncached_resp.sv
// Directed bench: one instance with WAIT_CYCLES=1 for the main checks, one with WAIT_CYCLES=0 for back-to-back throughput.
module tb_dmem_uncached_resp;

    localparam logic [31:0] BASE = 32'h9000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] addr = '0, wdat = '0;
    logic        rd = 1'b0, cach = 1'b0, inv = 1'b0, wb = 1'b0, fl = 1'b0;
    logic [3:0]  wr = '0;
    logic [10:0] tag = '0;

    logic [31:0] data1, data0;
    logic        acc1, ack1, err1, busy1, acc0, ack0, err0, busy0;
    logic [10:0] tag1, tag0;

    int checks = 0;
    int errors = 0;
    int lat;

    always #5 clk = ~clk;

    dmem_uncached_resp #(.BASE_ADDR(BASE), .DEPTH_WORDS(256), .WAIT_CYCLES(1)) u_dut1 (
        .clk_i(clk), .rst_ni(rst_n), .mem_addr_i(addr), .mem_data_wr_i(wdat),
        .mem_rd_i(rd), .mem_wr_i(wr), .mem_cacheable_i(cach), .mem_req_tag_i(tag),
        .mem_invalidate_i(inv), .mem_writeback_i(wb), .mem_flush_i(fl),
        .mem_data_rd_o(data1), .mem_accept_o(acc1), .mem_ack_o(ack1),
        .mem_error_o(err1), .mem_resp_tag_o(tag1), .busy_o(busy1)
    );

    dmem_uncached_resp #(.BASE_ADDR(BASE), .DEPTH_WORDS(256), .WAIT_CYCLES(0)) u_dut0 (
        .clk_i(clk), .rst_ni(rst_n), .mem_addr_i(addr), .mem_data_wr_i(wdat),
        .mem_rd_i(rd), .mem_wr_i(wr), .mem_cacheable_i(cach), .mem_req_tag_i(tag),
        .mem_invalidate_i(inv), .mem_writeback_i(wb), .mem_flush_i(fl),
        .mem_data_rd_o(data0), .mem_accept_o(acc0), .mem_ack_o(ack0),
        .mem_error_o(err0), .mem_resp_tag_o(tag0), .busy_o(busy0)
    );

    // Drive one request for exactly one rising edge (the transfer edge), then clear.
    task automatic send(input logic r, input logic [3:0] w, input logic [31:0] a,
                        input logic [31:0] d, input logic [10:0] t, input logic f);
        @(negedge clk);
        rd = r; wr = w; addr = a; wdat = d; tag = t; fl = f;
        @(posedge clk);
        #1;
        rd = 1'b0; wr = 4'h0; wdat = '0; fl = 1'b0;
    endtask

    // Extra rising edges after the transfer edge until ack1 is seen; -1 on timeout.
    task automatic wait_ack(output int l);
        l = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ack1) begin
                l = i;
                break;
            end
        end
    endtask

    task automatic test_reset;
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (ack1 !== 1'b0) begin errors++; $display("FAIL rst_ack: got %b want 0", ack1); end
        checks++; if (err1 !== 1'b0) begin errors++; $display("FAIL rst_err: got %b want 0", err1); end
        checks++; if (data1 !== 32'd0) begin errors++; $display("FAIL rst_data: got %h want 0", data1); end
        checks++; if (tag1 !== 11'd0) begin errors++; $display("FAIL rst_tag: got %h want 0", tag1); end
        checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy1); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (acc1 !== 1'b1) begin errors++; $display("FAIL rst_accept: got %b want 1", acc1); end
    endtask

    task automatic test_write_read;
        send(1'b0, 4'hF, BASE + 32'd8, 32'hDEADBEEF, 11'd5, 1'b0);
        wait_ack(lat);
        checks++; if (lat !== 1) begin errors++; $display("FAIL wr_latency: got %0d want 1", lat); end
        checks++; if (err1 !== 1'b0) begin errors++; $display("FAIL wr_err: got %b want 0", err1); end
        checks++; if (tag1 !== 11'd5) begin errors++; $display("FAIL wr_tag: got %h want 5", tag1); end
        checks++; if (data1 !== 32'd0) begin errors++; $display("FAIL wr_data: got %h want 0", data1); end
        send(1'b1, 4'h0, BASE + 32'd8, 32'd0, 11'd6, 1'b0);
        wait_ack(lat);
        checks++; if (data1 !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_data: got %h want deadbeef", data1); end
        checks++; if (tag1 !== 11'd6) begin errors++; $display("FAIL rd_tag: got %h want 6", tag1); end
        @(negedge clk);
        checks++; if (ack1 !== 1'b0) begin errors++; $display("FAIL ack_single: got %b want 0", ack1); end
        checks++; if (err1 !== 1'b0) begin errors++; $display("FAIL err_no_ack: got %b want 0", err1); end
        checks++; if (data1 !== 32'hDEADBEEF) begin errors++; $display("FAIL data_hold: got %h want deadbeef", data1); end
    endtask

    task automatic test_byte_lane;
        send(1'b0, 4'b0010, BASE + 32'd8, 32'h11223344, 11'd7, 1'b0);
        wait_ack(lat);
        checks++; if (err1 !== 1'b0) begin errors++; $display("FAIL lane_wr_err: got %b want 0", err1); end
        send(1'b1, 4'h0, BASE + 32'd8, 32'd0, 11'd8, 1'b0);
        wait_ack(lat);
        checks++; if (data1 !== 32'hDEAD33EF) begin errors++; $display("FAIL lane_rd_data: got %h want dead33ef", data1); end
    endtask

    task automatic test_range_err;
        send(1'b0, 4'hF, BASE, 32'h0BADF00D, 11'd10, 1'b0);
        wait_ack(lat);
        send(1'b0, 4'hF, BASE + 32'h3FC, 32'hA5A55A5A, 11'd11, 1'b0);
        wait_ack(lat);
        checks++; if (err1 !== 1'b0) begin errors++; $display("FAIL last_word_err: got %b want 0", err1); end
        send(1'b1, 4'h0, BASE - 32'd4, 32'd0, 11'd12, 1'b0);
        wait_ack(lat);
        checks++; if (err1 !== 1'b1) begin errors++; $display("FAIL below_err: got %b want 1", err1); end
        checks++; if (data1 !== 32'd0) begin errors++; $display("FAIL below_data: got %h want 0", data1); end
        checks++; if (tag1 !== 11'd12) begin errors++; $display("FAIL below_tag: got %h want 00c", tag1); end
        send(1'b1, 4'h0, BASE + 32'h400, 32'd0, 11'd13, 1'b0);
        wait_ack(lat);
        checks++; if (err1 !== 1'b1) begin errors++; $display("FAIL above_err: got %b want 1", err1); end
        checks++; if (data1 !== 32'd0) begin errors++; $display("FAIL above_data: got %h want 0", data1); end
        send(1'b0, 4'hF, BASE + 32'h400, 32'hFFFFFFFF, 11'd14, 1'b0);
        wait_ack(lat);
        checks++; if (err1 !== 1'b1) begin errors++; $display("FAIL above_wr_err: got %b want 1", err1); end
        send(1'b0, 4'hF, BASE - 32'd4, 32'hFFFFFFFF, 11'd15, 1'b0);
        wait_ack(lat);
        checks++; if (err1 !== 1'b1) begin errors++; $display("FAIL below_wr_err: got %b want 1", err1); end
        send(1'b1, 4'hF, BASE + 32'd8, 32'd0, 11'd16, 1'b0);
        wait_ack(lat);
        checks++; if (err1 !== 1'b1) begin errors++; $display("FAIL rdwr_err: got %b want 1", err1); end
        checks++; if (data1 !== 32'd0) begin errors++; $display("FAIL rdwr_data: got %h want 0", data1); end
        send(1'b1, 4'h0, BASE, 32'd0, 11'd17, 1'b0);
        wait_ack(lat);
        checks++; if (data1 !== 32'h0BADF00D) begin errors++; $display("FAIL word0_kept: got %h want 0badf00d", data1); end
        send(1'b1, 4'h0, BASE + 32'h3FC, 32'd0, 11'd18, 1'b0);
        wait_ack(lat);
        checks++; if (data1 !== 32'hA5A55A5A) begin errors++; $display("FAIL last_kept: got %h want a5a55a5a", data1); end
        send(1'b1, 4'h0, BASE + 32'd8, 32'd0, 11'd19, 1'b0);
        wait_ack(lat);
        checks++; if (data1 !== 32'hDEAD33EF) begin errors++; $display("FAIL word2_kept: got %h want dead33ef", data1); end
    endtask

    task automatic test_flush;
        send(1'b0, 4'h0, BASE + 32'd8, 32'hCAFEF00D, 11'h3F, 1'b1);
        wait_ack(lat);
        checks++; if (lat !== 1) begin errors++; $display("FAIL flush_latency: got %0d want 1", lat); end
        checks++; if (err1 !== 1'b0) begin errors++; $display("FAIL flush_err: got %b want 0", err1); end
        checks++; if (data1 !== 32'd0) begin errors++; $display("FAIL flush_data: got %h want 0", data1); end
        checks++; if (tag1 !== 11'h3F) begin errors++; $display("FAIL flush_tag: got %h want 03f", tag1); end
        send(1'b1, 4'h0, BASE + 32'd8, 32'd0, 11'd21, 1'b0);
        wait_ack(lat);
        checks++; if (data1 !== 32'hDEAD33EF) begin errors++; $display("FAIL flush_ram: got %h want dead33ef", data1); end
    endtask

    task automatic test_back_to_back;
        logic exp_acc [4];
        logic exp_ack [4];
        logic [10:0] exp_tag [4];
        exp_acc = '{1'b1, 1'b0, 1'b1, 1'b0};
        exp_ack = '{1'b0, 1'b1, 1'b0, 1'b1};
        exp_tag = '{11'd0, 11'd40, 11'd0, 11'd41};
        @(negedge clk);
        @(negedge clk);
        rd = 1'b1; addr = BASE + 32'd8; tag = 11'd40;
        for (int k = 0; k < 4; k++) begin
            checks++; if (acc0 !== exp_acc[k]) begin errors++; $display("FAIL b2b_accept[%0d]: got %b want %b", k, acc0, exp_acc[k]); end
            checks++; if (ack0 !== exp_ack[k]) begin errors++; $display("FAIL b2b_ack[%0d]: got %b want %b", k, ack0, exp_ack[k]); end
            if (exp_ack[k]) begin
                checks++; if (tag0 !== exp_tag[k]) begin errors++; $display("FAIL b2b_tag[%0d]: got %h want %h", k, tag0, exp_tag[k]); end
                checks++; if (data0 !== 32'hDEAD33EF) begin errors++; $display("FAIL b2b_data[%0d]: got %h want dead33ef", k, data0); end
            end
            if (k == 1) tag = 11'd41;
            @(negedge clk);
        end
        rd = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic test_reset_in_wait;
        logic seen;
        send(1'b1, 4'h0, BASE + 32'd8, 32'd0, 11'h55, 1'b0);
        @(negedge clk);
        checks++; if (busy1 !== 1'b1) begin errors++; $display("FAIL wait_busy: got %b want 1", busy1); end
        #1 rst_n = 1'b0;
        #1;
        checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL rst_wait_busy: got %b want 0", busy1); end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (ack1) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rst_no_ack: got %b want 0", seen); end
        checks++; if (acc1 !== 1'b1) begin errors++; $display("FAIL rst_accept_after: got %b want 1", acc1); end
        checks++; if (tag1 !== 11'd0) begin errors++; $display("FAIL rst_tag_after: got %h want 0", tag1); end
    endtask

    initial begin
        test_reset;
        test_write_read;
        test_byte_lane;
        test_range_err;
        test_flush;
        test_back_to_back;
        test_reset_in_wait;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
